ntt_butterfly_array: RTL and testbench
======================================

// Module: ntt_butterfly_array
// PURPOSE
//  LANES parallel modular butterflies with per-transaction mode select: CT forward
//  (NTT) or GS inverse (INTT), plus optional n^-1 scaling. Fully pipelined, II=1.
//  valid/ready handshake on both sides. An internal output FIFO with credit control
//  absorbs downstream backpressure, because the arithmetic pipeline never stalls.
//  Sits between the coefficient-memory read stage and the write-back stage of the
//  NTT engine.
// PARAMETERS
//  K           `K   coefficient/modulus width (bits)
//  LANES       4    parallel butterflies per transaction
//  MULT_LAT    10   modular multiplier latency (cycles)
//  ADD_LAT     2    modular add/sub latency (cycles)
//  TAG_W       8    sideband tag width, carried unchanged with data
//  FIFO_DEPTH  32   output FIFO entries; elaboration error if < LAT (below)
// PORTS
//  clk        in   1        clock
//  reset      in   1        asynchronous, active-high reset
//  q_m        in   K        modulus; static while busy=1
//  n_inv      in   K        n^-1 mod q_m; static while busy=1
//  in_valid   in   1        input transaction valid
//  in_ready   out  1        input may be accepted this cycle
//  in_mode    in   1        0 = CT (NTT), 1 = GS (INTT)
//  in_scale   in   1        1 = multiply both results by n_inv
//  in_a       in   LANES*K  lane i at [i*K +: K]
//  in_b       in   LANES*K  same lane packing as in_a
//  in_w       in   LANES*K  per-lane twiddle
//  in_tag     in   TAG_W    sideband tag
//  out_valid  out  1        output transaction valid
//  out_ready  in   1        consumer accepts output
//  out_a      out  LANES*K  lane results (first output)
//  out_b      out  LANES*K  lane results (second output)
//  out_tag    out  TAG_W    tag of the emitted transaction
//  busy       out  1        any transaction in flight or held in the FIFO
// BEHAVIOUR
//  - Accept when in_valid && in_ready. Emit when out_valid && out_ready. Strict in-order.
//  - Operands are in [0,q_m). All results are in [0,q_m). All arithmetic is mod q_m.
//  - CT: t=w*b; a'=a+t; b'=a-t. Order: mult (MULT_LAT) then add/sub (ADD_LAT).
//  - GS: a'=a+b; b'=(a-b)*w. Order: add/sub (ADD_LAT) then mult (MULT_LAT).
//    In GS, a' is delay-matched by MULT_LAT.
//  - Both modes take exactly MULT_LAT+ADD_LAT cycles through the core.
//    Mode, scale and tag travel with the data, so mixed modes back-to-back are legal.
//  - Scale stage (MULT_LAT): multiplies by n_inv if scale=1, else by 1. Always traversed.
//  - LAT = 2*MULT_LAT+ADD_LAT+1 (default 23): cycles from accept to out_valid,
//    given an empty FIFO and the +1 FIFO write register.
//  - Credit: in_ready = (inflight + fifo_count) < FIFO_DEPTH.
//    inflight increments on accept and decrements on FIFO write.
//    fifo_count increments on write and decrements on pop. Same-cycle events net out.
//  - Overflow is impossible by construction. An accept while in_ready=0 is ignored.
//  - FIFO: circular buffer with log2 pointers that wrap. Full and empty are taken
//    from the count, not from pointer equality. Simultaneous push and pop when full
//    or empty is legal.
//  - out_valid = fifo_count != 0. out_* show the FIFO head and hold stable while
//    out_valid && !out_ready.
//  - Reset (any time, including mid-operation): all valid bits, inflight,
//    fifo_count and pointers go to 0. in-flight data is discarded.
//    Reset values: out_valid=0, out_a/out_b/out_tag=0, busy=0,
//    in_ready=0 while reset is high, 1 from the first clk after release.
//  - Changing q_m or n_inv while busy=1 gives undefined results (bench checks it).
// STRUCTURE
//  - Shared package ntt_pkg: lane_t (logic[K-1:0]); struct bfly_ctl_t
//    {mode, scale, tag}; localparam function bfly_latency().
//  - Sub-module ntt_butterfly_lane: one CT/GS lane + scale stage, fixed LAT-1
//    latency, built on the codebase mod add/sub/mult units. Instantiated LANES
//    times via generate.
//  - Top level owns the ctl shift register, credit counter, FIFO and handshake.
// TESTING (q_m=17, n_inv=9, LANES=4, all lanes identical unless noted)
//  1 CT a=3,b=5,w=2,scale=0,tag=0x11 -> after 23 cycles out_a=13, out_b=10, tag=0x11.
//  2 GS a=3,b=5,w=2: scale=0 -> out_a=8, out_b=13; scale=1 -> out_a=4, out_b=15.
//  3 Wrap edges: CT a=16,b=16,w=16 -> out_a=0, out_b=15.
//    GS a=0,b=16,w=1 -> out_a=16, out_b=1.
//  4 Backpressure: out_ready=0, in_valid=1 -> exactly 32 accepts, then in_ready=0.
//    Set out_ready=1 -> 32 outputs, tags 0..31 in order, no loss or duplicates.
//  5 Alternate CT/GS every cycle for 100 random transactions, out_ready toggled
//    randomly -> outputs match a scoreboard model in order. busy=0 after drain.
//  6 Assert reset with 10 transactions in flight -> out_valid=0 and busy=0
//    immediately. First post-reset transaction emerges alone after 23 cycles.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and modular-arithmetic helpers for the NTT butterfly datapath.
// All helpers take operands already reduced into [0, q).
package ntt_pkg;

    localparam int unsigned CoeffW = 16;
    localparam int unsigned TagW   = 8;

    typedef logic [CoeffW-1:0] lane_t;

    typedef struct packed {
        logic            mode;   // 0 = CT forward, 1 = GS inverse
        logic            scale;  // multiply results by n^-1
        logic [TagW-1:0] tag;
    } bfly_ctl_t;

    // Accept-to-out_valid latency: core (mult + add/sub), scale mult, FIFO write.
    function automatic int unsigned bfly_latency(input int unsigned mult_lat,
                                                 input int unsigned add_lat);
        return 2 * mult_lat + add_lat + 1;
    endfunction

    function automatic lane_t mod_add(input lane_t a, input lane_t b, input lane_t q);
        logic [CoeffW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        return s[CoeffW-1:0];
    endfunction

    function automatic lane_t mod_sub(input lane_t a, input lane_t b, input lane_t q);
        return (a >= b) ? (a - b) : (a + (q - b));
    endfunction

    function automatic lane_t mod_mul(input lane_t a, input lane_t b, input lane_t q);
        logic [2*CoeffW-1:0] p;
        p = {{CoeffW{1'b0}}, a} * {{CoeffW{1'b0}}, b};
        return lane_t'(p % {{CoeffW{1'b0}}, q});
    endfunction

endpackage

// File: rtl/ntt_butterfly_lane.sv
// One CT/GS butterfly lane followed by the scale multiplier; 2*MULT_LAT+ADD_LAT cycles.
// Both orderings run in parallel and the mode picks one at the core output.
module ntt_butterfly_lane
    import ntt_pkg::*;
#(
    parameter int unsigned MULT_LAT = 10,
    parameter int unsigned ADD_LAT  = 2
) (
    input  logic  clk_i,
    input  lane_t q_m_i,
    input  lane_t n_inv_i,
    input  lane_t a_i,
    input  lane_t b_i,
    input  lane_t w_i,
    input  logic  mode_i,   // control of the transaction now at the core output
    input  logic  scale_i,
    output lane_t a_o,
    output lane_t b_o
);

    lane_t ct_t_q [MULT_LAT];
    lane_t ct_t_d [MULT_LAT];
    lane_t ct_a_q [MULT_LAT];
    lane_t ct_a_d [MULT_LAT];
    lane_t ct_x_q [ADD_LAT];
    lane_t ct_x_d [ADD_LAT];
    lane_t ct_y_q [ADD_LAT];
    lane_t ct_y_d [ADD_LAT];
    lane_t gs_x_q [ADD_LAT];
    lane_t gs_x_d [ADD_LAT];
    lane_t gs_y_q [ADD_LAT];
    lane_t gs_y_d [ADD_LAT];
    lane_t gs_w_q [ADD_LAT];
    lane_t gs_w_d [ADD_LAT];
    lane_t gs_a_q [MULT_LAT];
    lane_t gs_a_d [MULT_LAT];
    lane_t gs_b_q [MULT_LAT];
    lane_t gs_b_d [MULT_LAT];
    lane_t sc_a_q [MULT_LAT];
    lane_t sc_a_d [MULT_LAT];
    lane_t sc_b_q [MULT_LAT];
    lane_t sc_b_d [MULT_LAT];
    lane_t core_a, core_b, factor;

    always_comb begin
        core_a = mode_i ? gs_a_q[MULT_LAT-1] : ct_x_q[ADD_LAT-1];
        core_b = mode_i ? gs_b_q[MULT_LAT-1] : ct_y_q[ADD_LAT-1];
        factor = scale_i ? n_inv_i : lane_t'(1);

        ct_t_d[0] = mod_mul(w_i, b_i, q_m_i);
        ct_a_d[0] = a_i;
        ct_x_d[0] = mod_add(ct_a_q[MULT_LAT-1], ct_t_q[MULT_LAT-1], q_m_i);
        ct_y_d[0] = mod_sub(ct_a_q[MULT_LAT-1], ct_t_q[MULT_LAT-1], q_m_i);
        gs_x_d[0] = mod_add(a_i, b_i, q_m_i);
        gs_y_d[0] = mod_sub(a_i, b_i, q_m_i);
        gs_w_d[0] = w_i;
        gs_a_d[0] = gs_x_q[ADD_LAT-1];
        gs_b_d[0] = mod_mul(gs_y_q[ADD_LAT-1], gs_w_q[ADD_LAT-1], q_m_i);
        sc_a_d[0] = mod_mul(core_a, factor, q_m_i);
        sc_b_d[0] = mod_mul(core_b, factor, q_m_i);

        for (int i = 1; i < MULT_LAT; i++) begin
            ct_t_d[i] = ct_t_q[i-1];
            ct_a_d[i] = ct_a_q[i-1];
            gs_a_d[i] = gs_a_q[i-1];
            gs_b_d[i] = gs_b_q[i-1];
            sc_a_d[i] = sc_a_q[i-1];
            sc_b_d[i] = sc_b_q[i-1];
        end
        for (int i = 1; i < ADD_LAT; i++) begin
            ct_x_d[i] = ct_x_q[i-1];
            ct_y_d[i] = ct_y_q[i-1];
            gs_x_d[i] = gs_x_q[i-1];
            gs_y_d[i] = gs_y_q[i-1];
            gs_w_d[i] = gs_w_q[i-1];
        end
    end

    // Datapath needs no reset: validity is tracked by the top-level control pipe.
    always_ff @(posedge clk_i) begin
        ct_t_q <= ct_t_d;
        ct_a_q <= ct_a_d;
        ct_x_q <= ct_x_d;
        ct_y_q <= ct_y_d;
        gs_x_q <= gs_x_d;
        gs_y_q <= gs_y_d;
        gs_w_q <= gs_w_d;
        gs_a_q <= gs_a_d;
        gs_b_q <= gs_b_d;
        sc_a_q <= sc_a_d;
        sc_b_q <= sc_b_d;
    end

    assign a_o = sc_a_q[MULT_LAT-1];
    assign b_o = sc_b_q[MULT_LAT-1];

endmodule

// File: rtl/ntt_butterfly_array.sv
// LANES parallel NTT/INTT butterflies with a non-stalling pipeline, credit-based
// input flow control and an output FIFO that absorbs downstream backpressure.
module ntt_butterfly_array
    import ntt_pkg::*;
#(
    parameter int unsigned K          = CoeffW,
    parameter int unsigned LANES      = 4,
    parameter int unsigned MULT_LAT   = 10,
    parameter int unsigned ADD_LAT    = 2,
    parameter int unsigned TAG_W      = TagW,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [K-1:0]         q_m,
    input  logic [K-1:0]         n_inv,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic                 in_scale,
    input  logic [LANES*K-1:0]   in_a,
    input  logic [LANES*K-1:0]   in_b,
    input  logic [LANES*K-1:0]   in_w,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*K-1:0]   out_a,
    output logic [LANES*K-1:0]   out_b,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int unsigned Lat     = bfly_latency(MULT_LAT, ADD_LAT);
    localparam int unsigned PipeLat = Lat - 1;
    localparam int unsigned CoreLat = MULT_LAT + ADD_LAT;
    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DataW   = LANES * K;

    if (FIFO_DEPTH < Lat) begin : g_depth_chk
        $error("FIFO_DEPTH must be at least the accept-to-output latency");
    end
    if ((2 ** PtrW) != FIFO_DEPTH) begin : g_pow2_chk
        $error("FIFO_DEPTH must be a power of two");
    end
    if (K != CoeffW || TAG_W != TagW) begin : g_width_chk
        $error("K and TAG_W must match the ntt_pkg widths");
    end

    logic [PipeLat-1:0] vld_q, vld_d;
    bfly_ctl_t          ctl_q [PipeLat];
    bfly_ctl_t          ctl_d [PipeLat];
    logic               rdy_q, rdy_d;
    logic [CntW-1:0]    inflight_q, inflight_d, cnt_q, cnt_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DataW-1:0]   mem_a_q [FIFO_DEPTH];
    logic [DataW-1:0]   mem_a_d [FIFO_DEPTH];
    logic [DataW-1:0]   mem_b_q [FIFO_DEPTH];
    logic [DataW-1:0]   mem_b_d [FIFO_DEPTH];
    logic [TAG_W-1:0]   mem_t_q [FIFO_DEPTH];
    logic [TAG_W-1:0]   mem_t_d [FIFO_DEPTH];
    logic [DataW-1:0]   lane_a, lane_b;
    logic [CntW:0]      used;
    logic               accept, push, pop;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ntt_butterfly_lane #(
            .MULT_LAT (MULT_LAT),
            .ADD_LAT  (ADD_LAT)
        ) u_lane (
            .clk_i   (clk),
            .q_m_i   (q_m),
            .n_inv_i (n_inv),
            .a_i     (in_a[i*K +: K]),
            .b_i     (in_b[i*K +: K]),
            .w_i     (in_w[i*K +: K]),
            .mode_i  (ctl_q[CoreLat-1].mode),
            .scale_i (ctl_q[CoreLat-1].scale),
            .a_o     (lane_a[i*K +: K]),
            .b_o     (lane_b[i*K +: K])
        );
    end

    // Credit covers both in-flight and stored entries, so the FIFO can never overflow.
    assign used      = {1'b0, inflight_q} + {1'b0, cnt_q};
    assign in_ready  = rdy_q && (used < (CntW + 1)'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = vld_q[PipeLat-1];
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign busy      = (inflight_q != '0) || (cnt_q != '0);
    assign out_a     = out_valid ? mem_a_q[rd_ptr_q] : '0;
    assign out_b     = out_valid ? mem_b_q[rd_ptr_q] : '0;
    assign out_tag   = out_valid ? mem_t_q[rd_ptr_q] : '0;

    always_comb begin
        rdy_d    = 1'b1;
        vld_d    = {vld_q[PipeLat-2:0], accept};
        ctl_d[0] = '{mode: in_mode, scale: in_scale, tag: in_tag};
        for (int i = 1; i < PipeLat; i++) ctl_d[i] = ctl_q[i-1];
        inflight_d = inflight_q + CntW'(accept) - CntW'(push);
        cnt_d      = cnt_q + CntW'(push) - CntW'(pop);
        wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        mem_a_d = mem_a_q;
        mem_b_d = mem_b_q;
        mem_t_d = mem_t_q;
        if (push) begin
            mem_a_d[wr_ptr_q] = lane_a;
            mem_b_d[wr_ptr_q] = lane_b;
            mem_t_d[wr_ptr_q] = ctl_q[PipeLat-1].tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q      <= 1'b0;
            vld_q      <= '0;
            inflight_q <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < PipeLat; i++) ctl_q[i] <= '0;
        end else begin
            rdy_q      <= rdy_d;
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ctl_q      <= ctl_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_a_q <= mem_a_d;
        mem_b_q <= mem_b_d;
        mem_t_q <= mem_t_d;
    end

endmodule

// File: tb/tb_ntt_butterfly_array.sv
// Directed and randomised checks of ntt_butterfly_array against a per-lane
// modular-arithmetic model and an in-order scoreboard.
module tb_ntt_butterfly_array;
    import ntt_pkg::*;

    localparam int unsigned K     = CoeffW;
    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = LANES * K;
    localparam int unsigned Q     = 17;
    localparam int unsigned NINV  = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [K-1:0]  q_m, n_inv;
    logic          in_valid, in_ready, in_mode, in_scale;
    logic [DW-1:0] in_a, in_b, in_w;
    logic [7:0]    in_tag;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_a, out_b;
    logic [7:0]    out_tag;
    logic          busy;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [7:0]    tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ntt_butterfly_array dut (
        .clk       (clk),
        .reset     (reset),
        .q_m       (q_m),
        .n_inv     (n_inv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_scale  (in_scale),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_w      (in_w),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input int unsigned v);
        logic [DW-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*K +: K] = K'(v);
        return r;
    endfunction

    // Butterfly semantics straight from the modular equations, lane by lane.
    function automatic exp_t model(input logic m, input logic s, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input logic [DW-1:0] w,
                                   input logic [7:0] tag);
        exp_t e;
        for (int l = 0; l < LANES; l++) begin
            int unsigned x, y, z, t, ra, rb;
            x = a[l*K +: K];
            y = b[l*K +: K];
            z = w[l*K +: K];
            if (!m) begin
                t  = (z * y) % Q;
                ra = (x + t) % Q;
                rb = (x + Q - t) % Q;
            end else begin
                ra = (x + y) % Q;
                rb = (((x + Q - y) % Q) * z) % Q;
            end
            if (s) begin
                ra = (ra * NINV) % Q;
                rb = (rb * NINV) % Q;
            end
            e.a[l*K +: K] = K'(ra);
            e.b[l*K +: K] = K'(rb);
        end
        e.tag = tag;
        return e;
    endfunction

    // Compare process: head of FIFO against scoreboard on every valid cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got tag %h, required no output", out_tag);
                end else begin
                    chk("sb_out_a", out_a, sb[0].a);
                    chk("sb_out_b", out_b, sb[0].b);
                    chk("sb_out_tag", DW'(out_tag), DW'(sb[0].tag));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_mode, in_scale, in_a, in_b, in_w, in_tag));
        end
    end

    task automatic send(input logic m, input logic s, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] w, input logic [7:0] tag);
        int n;
        in_valid = 1'b1;
        in_mode  = m;
        in_scale = s;
        in_a     = a;
        in_b     = b;
        in_w     = w;
        in_tag   = tag;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready 0, required 1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called one time unit after the accepting edge; returns at a negedge.
    task automatic wait_out(output int lat);
        lat = 1;
        while (lat <= 100) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n_acc, n_pop;
        bit done;
        logic [DW-1:0] ra, rb, rw;
        q_m = K'(Q); n_inv = K'(NINV);
        in_valid = 0; in_mode = 0; in_scale = 0; in_a = '0; in_b = '0; in_w = '0; in_tag = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_in_ready", DW'(in_ready), '0);
        chk("rst_out_a", out_a, '0);
        chk("rst_out_tag", DW'(out_tag), '0);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_release", DW'(in_ready), DW'(1));

        // CT basic
        send(1'b0, 1'b0, rep(3), rep(5), rep(2), 8'h11);
        wait_out(lat);
        chk("ct_latency", DW'(lat), DW'(23));
        chk("ct_out_a", out_a, rep(13));
        chk("ct_out_b", out_b, rep(10));
        chk("ct_tag", DW'(out_tag), DW'(8'h11));
        @(posedge clk); #1;

        // GS unscaled then scaled, back to back
        send(1'b1, 1'b0, rep(3), rep(5), rep(2), 8'h21);
        send(1'b1, 1'b1, rep(3), rep(5), rep(2), 8'h22);
        wait_out(lat);
        chk("gs_out_a", out_a, rep(8));
        chk("gs_out_b", out_b, rep(13));
        @(posedge clk); @(negedge clk);
        chk("gs_scaled_out_a", out_a, rep(4));
        chk("gs_scaled_out_b", out_b, rep(15));
        @(posedge clk); #1;

        // Wrap edges
        send(1'b0, 1'b0, rep(16), rep(16), rep(16), 8'h31);
        send(1'b1, 1'b0, rep(0), rep(16), rep(1), 8'h32);
        wait_out(lat);
        chk("wrap_ct_out_a", out_a, rep(0));
        chk("wrap_ct_out_b", out_b, rep(15));
        @(posedge clk); @(negedge clk);
        chk("wrap_gs_out_a", out_a, rep(16));
        chk("wrap_gs_out_b", out_b, rep(1));
        @(posedge clk); #1;

        // Backpressure: credit must stop accepts at exactly FIFO depth
        out_ready = 1'b0;
        n_acc = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            in_tag  = 8'(n_acc);
            in_mode = n_acc[0];
            in_scale = n_acc[1];
            in_a = rep(n_acc % Q);
            in_b = rep((n_acc * 3) % Q);
            in_w = rep((n_acc * 5) % Q);
            @(negedge clk);
            if (in_ready) n_acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_accepts", DW'(n_acc), DW'(32));
        chk("bp_in_ready", DW'(in_ready), '0);
        out_ready = 1'b1;
        n_pop = 0;
        for (int c = 0; c < 100 && busy; c++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("bp_tag_order", DW'(out_tag), DW'(n_pop));
                n_pop++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_pops", DW'(n_pop), DW'(32));

        // Mixed modes with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    for (int l = 0; l < LANES; l++) begin
                        ra[l*K +: K] = K'($urandom_range(0, Q - 1));
                        rb[l*K +: K] = K'($urandom_range(0, Q - 1));
                        rw[l*K +: K] = K'($urandom_range(0, Q - 1));
                    end
                    send(i[0], 1'($urandom_range(0, 1)), ra, rb, rw, 8'(i));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("drain_busy", DW'(busy), '0);
        chk("drain_sb_empty", DW'(sb.size()), '0);
        @(posedge clk); #1;

        // Reset with transactions in flight and queued
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(1'b0, 1'b0, rep(i), rep(1), rep(1), 8'(8'h40 + i));
        repeat (15) @(posedge clk);
        #1 chk("pre_reset_out_valid", DW'(out_valid), DW'(1));
        #2 reset = 1'b1;
        #1;
        sb.delete();
        chk("mid_reset_out_valid", DW'(out_valid), '0);
        chk("mid_reset_busy", DW'(busy), '0);
        chk("mid_reset_in_ready", DW'(in_ready), '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(1'b1, 1'b1, rep(3), rep(5), rep(2), 8'hA5);
        wait_out(lat);
        chk("post_reset_latency", DW'(lat), DW'(23));
        chk("post_reset_tag", DW'(out_tag), DW'(8'hA5));
        chk("post_reset_out_a", out_a, rep(4));
        @(posedge clk); @(negedge clk);
        chk("post_reset_alone", DW'(out_valid), '0);
        chk("post_reset_idle", DW'(busy), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
